// File: rtl/game_pkg.sv
// Shared game constants and types for the projectile and cat drawing stages.
// The cat box geometry lives here so both stages agree on where the cat is.
package game_pkg;

  localparam int TARGET_X = 1;
  localparam int TARGET_Y = 430;
  localparam int TARGET_W = 157;
  localparam int TARGET_H = 99;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    IMPACT = 2'd2
  } proj_state_t;

  // 1-D overlap of half-open spans [a_lo, a_lo+a_len) and [b_lo, b_lo+b_len).
  function automatic logic span_overlap(input int a_lo, input int a_len,
                                        input int b_lo, input int b_len);
    return (a_lo < b_lo + b_len) && (b_lo < a_lo + a_len);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle: timing counters, sync/blank strobes and colour.
// The stream has no backpressure: every field is valid on every clock and is never stalled.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/projectile_physics.sv
// Projectile FSM and per-frame kinematics: launch, gravity, hit/miss detection, cooldown.
// Everything except launch advances only on the frame tick (rising edge of the delayed vblnk).
module projectile_physics
  import game_pkg::*;
#(
  parameter int START_X   = 900,
  parameter int START_Y   = 430,
  parameter int PROJ_SIZE = 16,
  parameter int GRAVITY   = 1,
  parameter int GROUND_Y  = 529,
  parameter int COOLDOWN  = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fire,
  input  logic [5:0]         vel_x,
  input  logic [6:0]         vel_y,
  input  logic               vblnk,
  output logic signed [11:0] pos_x,
  output logic signed [11:0] pos_y,
  output logic               draw_en,
  output logic               hit_cat,
  output logic               busy,
  output proj_state_t        state
);

  logic              vblnk_prev;
  logic              armed;
  logic [5:0]        vx;
  logic signed [8:0] vy;
  logic [5:0]        cool_cnt;

  logic              tick;
  logic signed [11:0] nx, ny;
  logic signed [9:0]  vy_dec;
  logic signed [8:0]  vy_next;
  logic              hit, miss;

  assign tick    = vblnk & ~vblnk_prev;
  assign draw_en = (state == FLIGHT);

  always_comb begin
    nx      = pos_x - $signed({6'd0, vx});
    ny      = pos_y - $signed({{3{vy[8]}}, vy});
    vy_dec  = $signed({vy[8], vy}) - $signed(10'(GRAVITY));
    vy_next = (vy_dec < -10'sd256) ? -9'sd256 : vy_dec[8:0];
    hit     = span_overlap(int'(nx), PROJ_SIZE, TARGET_X, TARGET_W) &&
              span_overlap(int'(ny), PROJ_SIZE, TARGET_Y, TARGET_H);
    miss    = (int'(ny) + PROJ_SIZE > GROUND_Y) || (int'(nx) + PROJ_SIZE <= 0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pos_x      <= '0;
      pos_y      <= '0;
      vx         <= '0;
      vy         <= '0;
      cool_cnt   <= '0;
      hit_cat    <= 1'b0;
      busy       <= 1'b0;
      armed      <= 1'b1;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vblnk;
      hit_cat    <= 1'b0;
      // A held fire must drop for a cycle before it can launch again.
      if (!fire) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (fire && armed) begin
            state <= FLIGHT;
            pos_x <= 12'(START_X);
            pos_y <= 12'(START_Y);
            vx    <= vel_x;
            vy    <= {2'b00, vel_y};
            armed <= 1'b0;
            busy  <= 1'b1;
          end
        end
        FLIGHT: begin
          if (tick) begin
            pos_x <= nx;
            pos_y <= ny;
            vy    <= vy_next;
            if (hit) begin
              state   <= IMPACT;
              hit_cat <= 1'b1;
            end else if (miss) begin
              state <= IMPACT;
            end
          end
        end
        IMPACT: begin
          if (tick) begin
            if (cool_cnt == 6'(COOLDOWN - 1)) begin
              state    <= IDLE;
              busy     <= 1'b0;
              cool_cnt <= '0;
            end else begin
              cool_cnt <= cool_cnt + 6'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/draw_projectile.sv
// VGA stage that launches, moves and draws a ballistic projectile and flags cat hits.
// The pixel stream is delayed by one clock; the projectile square overrides unblanked pixels.
module draw_projectile
  import game_pkg::*;
#(
  parameter int          START_X   = 900,
  parameter int          START_Y   = 430,
  parameter int          PROJ_SIZE = 16,
  parameter logic [11:0] PROJ_RGB  = 12'hFF0,
  parameter int          GRAVITY   = 1,
  parameter int          GROUND_Y  = 529,
  parameter int          COOLDOWN  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fire,
  input  logic [5:0]  vel_x,
  input  logic [6:0]  vel_y,
  output logic        hit_cat,
  output logic        busy,
  output proj_state_t state,
  vga_if.vga_in       vga_in,
  vga_if.vga_out      vga_out
);

  logic signed [11:0] pos_x, pos_y;
  logic               draw_en;

  logic [10:0] hcount_d, vcount_d;
  logic        hsync_d, vsync_d, hblnk_d, vblnk_d;
  logic [11:0] rgb_d;

  logic signed [12:0] px, py, bx, by, sz;
  logic               pixel_on;

  projectile_physics #(
    .START_X  (START_X),
    .START_Y  (START_Y),
    .PROJ_SIZE(PROJ_SIZE),
    .GRAVITY  (GRAVITY),
    .GROUND_Y (GROUND_Y),
    .COOLDOWN (COOLDOWN)
  ) u_physics (
    .clk    (clk),
    .rst    (rst),
    .fire   (fire),
    .vel_x  (vel_x),
    .vel_y  (vel_y),
    .vblnk  (vblnk_d),
    .pos_x  (pos_x),
    .pos_y  (pos_y),
    .draw_en(draw_en),
    .hit_cat(hit_cat),
    .busy   (busy),
    .state  (state)
  );

  // Signed 13-bit compares so a box partly off the left/top edge still clips correctly.
  always_comb begin
    px       = $signed({2'b00, vga_in.hcount});
    py       = $signed({2'b00, vga_in.vcount});
    bx       = {pos_x[11], pos_x};
    by       = {pos_y[11], pos_y};
    sz       = $signed(13'(PROJ_SIZE));
    pixel_on = draw_en && !(vga_in.hblnk || vga_in.vblnk) &&
               (px >= bx) && (px < bx + sz) &&
               (py >= by) && (py < by + sz);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_d <= '0;
      vcount_d <= '0;
      hsync_d  <= 1'b0;
      vsync_d  <= 1'b0;
      hblnk_d  <= 1'b0;
      vblnk_d  <= 1'b0;
      rgb_d    <= '0;
    end else begin
      hcount_d <= vga_in.hcount;
      vcount_d <= vga_in.vcount;
      hsync_d  <= vga_in.hsync;
      vsync_d  <= vga_in.vsync;
      hblnk_d  <= vga_in.hblnk;
      vblnk_d  <= vga_in.vblnk;
      rgb_d    <= pixel_on ? PROJ_RGB : vga_in.rgb;
    end
  end

  assign vga_out.hcount = hcount_d;
  assign vga_out.vcount = vcount_d;
  assign vga_out.hsync  = hsync_d;
  assign vga_out.vsync  = vsync_d;
  assign vga_out.hblnk  = hblnk_d;
  assign vga_out.vblnk  = vblnk_d;
  assign vga_out.rgb    = rgb_d;

endmodule
